trng_sampler_ctrl: RTL

- Sequencer and arbiter for the SR-latch entropy network. Drives the network's enable, waits for metastability settling, then samples its single output bit into a WORD_W-bit word.
- Shares the one entropy source between two requesters with round-robin arbitration.
- Runs a continuous repetition-count health test and latches a sticky fault.
- Sits between the latch network (ent_enable/ent_bit) and consumer logic (req/gnt plus a valid/ready response channel).

---
 rtl/trng_sampler_ctrl_if.sv | 30 +++
 rtl/trng_sampler_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/trng_sampler_ctrl_if.sv
// Request/grant and word-response channel between the TRNG sampler and its two consumers.
// master = consumer side, slave = sampler controller.
interface trng_sampler_ctrl_if #(
  parameter int WORD_W = 8
) ();
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_data;
  logic              rsp_id;

  modport master (
    output req,
    output rsp_ready,
    input  gnt,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id
  );

  modport slave (
    input  req,
    input  rsp_ready,
    output gnt,
    output rsp_valid,
    output rsp_data,
    output rsp_id
  );
endinterface

// File: rtl/trng_sampler_ctrl.sv
// Sequencer/arbiter for the SR-latch entropy network with a sticky repetition-count health test.
// Define TRNG_VON_NEUMANN_EN to debias raw sample pairs before they enter the word.
module trng_sampler_ctrl #(
  parameter int WORD_W        = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_DIV    = 2,
  parameter int REP_LIMIT     = 16
) (
  input  logic               clk,
  input  logic               reset,
  trng_sampler_ctrl_if.slave bus,
  output logic               ent_enable,
  input  logic               ent_bit,
  output logic               busy,
  output logic               health_fail
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int WIN_W = $clog2(SAMPLE_DIV + 1);
  localparam int RUN_W = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    SAMPLE  = 3'd2,
    DELIVER = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t            state_r;
  logic [1:0]        gnt_r;
  logic              rsp_valid_r;
  logic [WORD_W-1:0] rsp_data_r;
  logic              rsp_id_r;
  logic              ent_enable_r;
  logic              busy_r;
  logic              health_fail_r;
  logic              rr_ptr_r;
  logic [WORD_W-1:0] shift_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [SET_W-1:0]  set_cnt_r;
  logic [WIN_W-1:0]  win_cnt_r;
  logic [RUN_W-1:0]  run_cnt_r;
  logic              last_bit_r;
`ifdef TRNG_VON_NEUMANN_EN
  logic              pair_have_r;
  logic              pair_first_r;
`endif

  logic              sample_tick_s;
  logic              emit_s;
  logic              emit_bit_s;
  logic              trip_s;
  logic              word_done_s;
  logic              winner_s;
  logic [RUN_W-1:0]  run_next_s;
  logic [WORD_W-1:0] shift_next_s;

  // Sample strobe, health-run update, emitted bit and arbitration winner
  always_comb begin
    sample_tick_s = (state_r == SAMPLE) && (win_cnt_r == WIN_W'(SAMPLE_DIV - 1));
    if (ent_bit == last_bit_r) begin
      run_next_s = run_cnt_r + RUN_W'(1);
    end else begin
      run_next_s = RUN_W'(1);
    end
    trip_s = sample_tick_s && (run_next_s >= RUN_W'(REP_LIMIT));
`ifdef TRNG_VON_NEUMANN_EN
    // 10 emits 1, 01 emits 0: the emitted value is the first bit of a differing pair
    emit_s     = sample_tick_s && pair_have_r && (pair_first_r != ent_bit);
    emit_bit_s = pair_first_r;
`else
    emit_s     = sample_tick_s;
    emit_bit_s = ent_bit;
`endif
    shift_next_s = (shift_r << 1'b1) | WORD_W'(emit_bit_s);
    word_done_s  = emit_s && (bit_cnt_r == CNT_W'(WORD_W - 1));
    if (bus.req[rr_ptr_r]) begin
      winner_s = rr_ptr_r;
    end else begin
      winner_s = ~rr_ptr_r;
    end
  end

  // Transaction FSM, counters, health state and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      gnt_r         <= 2'b00;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= '0;
      rsp_id_r      <= 1'b0;
      ent_enable_r  <= 1'b0;
      busy_r        <= 1'b0;
      health_fail_r <= 1'b0;
      rr_ptr_r      <= 1'b0;
      shift_r       <= '0;
      bit_cnt_r     <= '0;
      set_cnt_r     <= '0;
      win_cnt_r     <= '0;
      run_cnt_r     <= '0;
      last_bit_r    <= 1'b0;
`ifdef TRNG_VON_NEUMANN_EN
      pair_have_r   <= 1'b0;
      pair_first_r  <= 1'b0;
`endif
    end else begin
      if (sample_tick_s) begin
        last_bit_r <= ent_bit;
        run_cnt_r  <= run_next_s;
      end
      case (state_r)
        IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_r        <= winner_s ? 2'b10 : 2'b01;
            rsp_id_r     <= winner_s;
            ent_enable_r <= 1'b1;
            busy_r       <= 1'b1;
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            set_cnt_r    <= '0;
            win_cnt_r    <= '0;
`ifdef TRNG_VON_NEUMANN_EN
            pair_have_r  <= 1'b0;
`endif
            state_r      <= SETTLE;
          end
        end
        SETTLE: begin
          if (set_cnt_r == SET_W'(SETTLE_CYCLES - 1)) begin
            state_r <= SAMPLE;
          end else begin
            set_cnt_r <= set_cnt_r + SET_W'(1);
          end
        end
        SAMPLE: begin
          // A health trip wins over word completion: the in-flight word is dropped
          if (trip_s) begin
            state_r       <= FAULT;
            health_fail_r <= 1'b1;
            ent_enable_r  <= 1'b0;
            gnt_r         <= 2'b00;
          end else begin
            if (sample_tick_s) begin
              win_cnt_r <= '0;
            end else begin
              win_cnt_r <= win_cnt_r + WIN_W'(1);
            end
`ifdef TRNG_VON_NEUMANN_EN
            if (sample_tick_s) begin
              pair_have_r  <= ~pair_have_r;
              pair_first_r <= ent_bit;
            end
`endif
            if (emit_s) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
            if (word_done_s) begin
              ent_enable_r <= 1'b0;
              rsp_data_r   <= shift_next_s;
              rsp_valid_r  <= 1'b1;
              state_r      <= DELIVER;
            end
          end
        end
        DELIVER: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            gnt_r       <= 2'b00;
            rr_ptr_r    <= ~rsp_id_r;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        FAULT: begin
          state_r <= FAULT;
        end
        default: begin
          state_r      <= IDLE;
          gnt_r        <= 2'b00;
          ent_enable_r <= 1'b0;
          rsp_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign ent_enable    = ent_enable_r;
  assign busy          = busy_r;
  assign health_fail   = health_fail_r;

endmodule
